// File: rtl/anycore_l15_pkg.sv
// Shared types and L1.5 request encodings for the AnyCore-to-L1.5 request path.
// Request type and size codes match the OpenPiton iop.h definitions.
package anycore_l15_pkg;

    localparam int PHY_ADDR_WIDTH = 40;

    localparam logic [4:0] LOAD_RQ  = 5'b00000;
    localparam logic [4:0] IMISS_RQ = 5'b10000;
    localparam logic [4:0] STORE_RQ = 5'b00001;
    localparam logic [2:0] PCX_SZ_4B = 3'b010;

    typedef enum logic [1:0] {
        IMISS = 2'd0,
        LD    = 2'd1,
        ST    = 2'd2
    } src_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [PHY_ADDR_WIDTH-1:0] addr;
        logic [63:0]               data;
        logic [2:0]                size;
    } l15_req_t;

    // Round-robin successor: imiss -> load -> store -> imiss.
    function automatic src_e next_src(input src_e s);
        case (s)
            IMISS:   next_src = LD;
            LD:      next_src = ST;
            default: next_src = IMISS;
        endcase
    endfunction

    // AnyCore stores are little-endian; the L1.5 expects byte 0 in the top lane.
    function automatic logic [63:0] bswap64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[63-8*i -: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/anycore_req_fifo.sv
// Small per-source request FIFO; exposes the head and the entry behind it so the
// arbiter can pick a second entry from the same source on the pop edge.
module anycore_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     rdy,
    output logic [WIDTH-1:0]         head,
    output logic [WIDTH-1:0]         head_next,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign rdy       = (count != (PTR_W+1)'(DEPTH));
    assign do_push   = push && rdy;
    assign do_pop    = pop && (count != '0);
    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + PTR_W'(1)];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/anycore_l15_req_arbiter.sv
// Merges the imiss, load and store request streams onto the single L1.5 request
// port, holding each presented request stable until the L1.5 acknowledges it.
module anycore_l15_req_arbiter
    import anycore_l15_pkg::*;
#(
    parameter int ADDR_W     = PHY_ADDR_WIDTH,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 2,
    parameter int IMISS_PRIO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imiss_val,
    output logic              imiss_rdy,
    input  logic [ADDR_W-1:0] imiss_addr,
    input  logic              ld_val,
    output logic              ld_rdy,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              st_val,
    output logic              st_rdy,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [2:0]        st_size,
    output logic              l15_val,
    output logic [4:0]        l15_rqtype,
    output logic [ADDR_W-1:0] l15_address,
    output logic [63:0]       l15_data,
    output logic [2:0]        l15_size,
    input  logic              l15_ack,
    output logic              arb_busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ST_W  = ADDR_W + DATA_W + 3;

    logic [CNT_W-1:0]  im_cnt, ld_cnt, st_cnt;
    logic [ADDR_W-1:0] im_head, im_next, ld_head, ld_next;
    logic [ST_W-1:0]   st_head, st_next;
    logic [ADDR_W-1:0] im_sel, ld_sel;
    logic [ST_W-1:0]   st_sel;
    logic              pop_im, pop_ld, pop_st;
    logic              hold_ack, any_elig, load_out;
    logic [2:0]        elig;
    src_e              winner, rr_eff, grant_q, rr_q;
    arb_state_e        state_q, state_d;

    anycore_req_fifo #(.WIDTH(ADDR_W), .DEPTH(FIFO_DEPTH)) u_im_fifo (
        .clk(clk), .rst(rst), .push(imiss_val), .push_data(imiss_addr), .pop(pop_im),
        .rdy(imiss_rdy), .head(im_head), .head_next(im_next), .count(im_cnt)
    );

    anycore_req_fifo #(.WIDTH(ADDR_W), .DEPTH(FIFO_DEPTH)) u_ld_fifo (
        .clk(clk), .rst(rst), .push(ld_val), .push_data(ld_addr), .pop(pop_ld),
        .rdy(ld_rdy), .head(ld_head), .head_next(ld_next), .count(ld_cnt)
    );

    anycore_req_fifo #(.WIDTH(ST_W), .DEPTH(FIFO_DEPTH)) u_st_fifo (
        .clk(clk), .rst(rst), .push(st_val), .push_data({st_addr, st_data, st_size}),
        .pop(pop_st), .rdy(st_rdy), .head(st_head), .head_next(st_next), .count(st_cnt)
    );

    assign hold_ack = (state_q == S_HOLD) && l15_ack;
    assign pop_im   = hold_ack && (grant_q == IMISS);
    assign pop_ld   = hold_ack && (grant_q == LD);
    assign pop_st   = hold_ack && (grant_q == ST);
    assign rr_eff   = hold_ack ? next_src(grant_q) : rr_q;

    // Eligibility looks past the entry being popped on this edge.
    always_comb begin
        elig    = '0;
        elig[0] = pop_im ? (im_cnt > CNT_W'(1)) : (im_cnt != '0);
        elig[1] = pop_ld ? (ld_cnt > CNT_W'(1)) : (ld_cnt != '0);
        elig[2] = pop_st ? (st_cnt > CNT_W'(1)) : (st_cnt != '0);
        im_sel  = pop_im ? im_next : im_head;
        ld_sel  = pop_ld ? ld_next : ld_head;
        st_sel  = pop_st ? st_next : st_head;
    end

    assign any_elig = |elig;
    assign load_out = any_elig && ((state_q == S_IDLE) || hold_ack);

    always_comb begin
        src_e s0, s1, s2;
        winner = LD;
        s0 = rr_eff;
        s1 = next_src(s0);
        s2 = next_src(s1);
        if (IMISS_PRIO != 0) begin
            if (elig[IMISS])    winner = IMISS;
            else if (rr_eff == ST) winner = elig[ST] ? ST : LD;
            else                winner = elig[LD] ? LD : ST;
        end else begin
            if (elig[s2]) winner = s2;
            if (elig[s1]) winner = s1;
            if (elig[s0]) winner = s0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_elig) state_d = S_HOLD;
            S_HOLD:  if (l15_ack && !any_elig) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        l15_val  = (state_q == S_HOLD);
        arb_busy = (im_cnt != '0) || (ld_cnt != '0) || (st_cnt != '0) || l15_val;
    end

    // Output registers only change when a new winner is loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q     <= IMISS;
            rr_q        <= LD;
            l15_rqtype  <= '0;
            l15_address <= '0;
            l15_data    <= '0;
            l15_size    <= '0;
        end else begin
            if (hold_ack) rr_q <= next_src(grant_q);
            if (load_out) begin
                grant_q <= winner;
                case (winner)
                    IMISS: begin
                        l15_rqtype  <= IMISS_RQ;
                        l15_address <= im_sel;
                        l15_data    <= '0;
                        l15_size    <= PCX_SZ_4B;
                    end
                    LD: begin
                        l15_rqtype  <= LOAD_RQ;
                        l15_address <= ld_sel;
                        l15_data    <= '0;
                        l15_size    <= PCX_SZ_4B;
                    end
                    default: begin
                        l15_rqtype  <= STORE_RQ;
                        l15_address <= st_sel[ST_W-1 -: ADDR_W];
                        l15_data    <= bswap64(64'(st_sel[3 +: DATA_W]));
                        l15_size    <= st_sel[2:0];
                    end
                endcase
            end
        end
    end

endmodule
